// File: rtl/risc_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit:
// word and register-address widths, opcodes and the control FSM encoding.
package risc_pkg;
   localparam int WORD_W     = 16;
   localparam int REG_ADDR_W = 3;

   localparam logic [1:0] OP_MULLO = 2'b00;
   localparam logic [1:0] OP_MULHI = 2'b01;
   localparam logic [1:0] OP_DIVQ  = 2'b10;
   localparam logic [1:0] OP_DIVR  = 2'b11;

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} md_state_t;
endpackage

// File: rtl/md_datapath.sv
// One-bit-per-step datapath: shift-add multiply on {acc,mq}, restoring divide
// with acc as partial remainder and mq as dividend/quotient.
import risc_pkg::*;

module md_datapath #(
   parameter int WIDTH = WORD_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic             step_i,
   input  logic [1:0]       op_i,
   input  logic [WIDTH-1:0] src_a_i,
   input  logic [WIDTH-1:0] src_b_i,
   output logic [WIDTH-1:0] res_o,
   output logic             div_zero_o
);
   logic [WIDTH:0]   acc_q, acc_d;
   logic [WIDTH-1:0] mq_q, mq_d;
   logic [WIDTH-1:0] opnd_q, opnd_d;
   logic [1:0]       op_q, op_d;
   logic [WIDTH:0]   sum, shifted;
   logic [WIDTH+1:0] diff;

   always_comb begin
      acc_d   = acc_q;
      mq_d    = mq_q;
      opnd_d  = opnd_q;
      op_d    = op_q;
      sum     = '0;
      shifted = '0;
      diff    = '0;
      if (load_i) begin
         // mq holds the multiplier for MUL and the dividend for DIV
         acc_d  = '0;
         mq_d   = op_i[1] ? src_a_i : src_b_i;
         opnd_d = op_i[1] ? src_b_i : src_a_i;
         op_d   = op_i;
      end else if (step_i) begin
         if (!op_q[1]) begin
            sum   = acc_q + {1'b0, (mq_q[0] ? opnd_q : '0)};
            acc_d = {1'b0, sum[WIDTH:1]};
            mq_d  = {sum[0], mq_q[WIDTH-1:1]};
         end else begin
            shifted = {acc_q[WIDTH-1:0], mq_q[WIDTH-1]};
            diff    = {1'b0, shifted} - {2'b00, opnd_q};
            // A zero divisor never borrows: quotient all ones, remainder = dividend
            if (diff[WIDTH+1]) begin
               acc_d = shifted;
               mq_d  = {mq_q[WIDTH-2:0], 1'b0};
            end else begin
               acc_d = diff[WIDTH:0];
               mq_d  = {mq_q[WIDTH-2:0], 1'b1};
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q  <= '0;
         mq_q   <= '0;
         opnd_q <= '0;
         op_q   <= OP_MULLO;
      end else begin
         acc_q  <= acc_d;
         mq_q   <= mq_d;
         opnd_q <= opnd_d;
         op_q   <= op_d;
      end
   end

   // Post-step view so the FSM can capture the answer on the final step edge
   assign res_o      = op_q[0] ? acc_d[WIDTH-1:0] : mq_d;
   assign div_zero_o = op_q[1] && (opnd_q == '0);
endmodule

// File: rtl/mul_div_unit.sv
// Iterative unsigned multiply/divide with write-back controls; the core stalls
// on busy, and result/wb_reg/div_zero hold until the next completion.
import risc_pkg::*;

module mul_div_unit #(
   parameter int WIDTH      = WORD_W,
   parameter int REG_ADDR_W = risc_pkg::REG_ADDR_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [1:0]            op,
   input  logic [WIDTH-1:0]      src_a,
   input  logic [WIDTH-1:0]      src_b,
   input  logic [REG_ADDR_W-1:0] dest_reg,
   output logic                  busy,
   output logic                  done,
   output logic [WIDTH-1:0]      result,
   output logic                  wb_en,
   output logic [REG_ADDR_W-1:0] wb_reg,
   output logic                  div_zero
);
   localparam int CNT_W = $clog2(WIDTH);

   md_state_t             state_q;
   logic [CNT_W-1:0]      count_q;
   logic                  done_q, dz_q;
   logic [WIDTH-1:0]      result_q;
   logic [REG_ADDR_W-1:0] dest_q, wb_reg_q;
   logic                  load, step, dp_dz;
   logic [WIDTH-1:0]      dp_res;

   assign load = start && (state_q != S_CALC);
   assign step = (state_q == S_CALC);

   md_datapath #(.WIDTH(WIDTH)) u_dp (
      .clk        (clk),
      .rst        (rst),
      .load_i     (load),
      .step_i     (step),
      .op_i       (op),
      .src_a_i    (src_a),
      .src_b_i    (src_b),
      .res_o      (dp_res),
      .div_zero_o (dp_dz)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         count_q  <= '0;
         done_q   <= 1'b0;
         dz_q     <= 1'b0;
         result_q <= '0;
         dest_q   <= '0;
         wb_reg_q <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start) begin
                  dest_q  <= dest_reg;
                  count_q <= '0;
                  state_q <= S_CALC;
               end else begin
                  state_q <= S_IDLE;
               end
            end
            S_CALC: begin
               count_q <= count_q + 1'b1;
               if (count_q == CNT_W'(WIDTH - 1)) begin
                  state_q  <= S_DONE;
                  done_q   <= 1'b1;
                  result_q <= dp_res;
                  wb_reg_q <= dest_q;
                  dz_q     <= dp_dz;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy     = (state_q == S_CALC);
   assign done     = done_q;
   assign wb_en    = done_q;
   assign result   = result_q;
   assign wb_reg   = wb_reg_q;
   assign div_zero = dz_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: reset, each op, divide-by-zero,
// start while busy and back-to-back issue, with hand-computed expectations.
import risc_pkg::*;

module tb_mul_div_unit;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [15:0] src_a = '0, src_b = '0;
   logic [2:0]  dest_reg = '0;
   logic        busy, done, wb_en, div_zero;
   logic [15:0] result;
   logic [2:0]  wb_reg;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mul_div_unit dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
      .dest_reg(dest_reg), .busy(busy), .done(done), .result(result),
      .wb_en(wb_en), .wb_reg(wb_reg), .div_zero(div_zero)
   );

   // Issue one op from idle and wait (bounded) for done; lat counts edges after acceptance
   task automatic issue(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                        input logic [2:0] d, output int lat);
      @(negedge clk);
      start = 1'b1; op = o; src_a = a; src_b = b; dest_reg = d;
      @(posedge clk); #1;
      start = 1'b0; src_a = 16'h5A5A; src_b = 16'hA5A5; dest_reg = 3'd7;
      lat = 0;
      while (!done && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic settle();
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
      checks++; if (done !== 1'b0 || wb_en !== 1'b0) begin errors++; $display("FAIL reset_done got %b/%b exp 0/0", done, wb_en); end
      checks++; if (result !== 16'h0) begin errors++; $display("FAIL reset_result got %h exp 0000", result); end
      checks++; if (wb_reg !== 3'd0 || div_zero !== 1'b0) begin errors++; $display("FAIL reset_wb got %0d/%b exp 0/0", wb_reg, div_zero); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_mullo();
      int lat;
      issue(OP_MULLO, 16'd300, 16'd200, 3'd5, lat);
      checks++; if (lat != 16) begin errors++; $display("FAIL mullo_latency got %0d exp 16", lat); end
      checks++; if (result !== 16'hEA60) begin errors++; $display("FAIL mullo_result got %h exp ea60", result); end
      checks++; if (wb_reg !== 3'd5 || wb_en !== 1'b1) begin errors++; $display("FAIL mullo_wb got %0d/%b exp 5/1", wb_reg, wb_en); end
      checks++; if (busy !== 1'b0 || div_zero !== 1'b0) begin errors++; $display("FAIL mullo_flags got busy %b dz %b exp 0/0", busy, div_zero); end
      @(posedge clk); #1;
      checks++; if (done !== 1'b0 || wb_en !== 1'b0) begin errors++; $display("FAIL mullo_pulse got %b/%b exp 0/0", done, wb_en); end
      checks++; if (result !== 16'hEA60 || wb_reg !== 3'd5) begin errors++; $display("FAIL mullo_hold got %h/%0d exp ea60/5", result, wb_reg); end
   endtask

   task automatic test_mid_reset();
      bit seen = 1'b0;
      @(negedge clk);
      start = 1'b1; op = OP_MULLO; src_a = 16'd5; src_b = 16'd5; dest_reg = 3'd4;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before got %b exp 1", busy); end
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++; if (busy !== 1'b0 || done !== 1'b0 || wb_en !== 1'b0) begin errors++; $display("FAIL midrst_ctrl got %b%b%b exp 000", busy, done, wb_en); end
      checks++; if (result !== 16'h0 || wb_reg !== 3'd0 || div_zero !== 1'b0) begin errors++; $display("FAIL midrst_out got %h/%0d/%b exp 0000/0/0", result, wb_reg, div_zero); end
      @(negedge clk);
      rst = 1'b0;
      repeat (25) begin
         @(posedge clk); #1;
         if (done || busy) seen = 1'b1;
      end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midrst_no_done got %b exp 0", seen); end
   endtask

   task automatic test_mul_ext();
      int lat;
      issue(OP_MULHI, 16'hFFFF, 16'hFFFF, 3'd2, lat);
      checks++; if (lat != 16 || result !== 16'hFFFE) begin errors++; $display("FAIL mulhi got lat %0d res %h exp 16/fffe", lat, result); end
      settle();
      issue(OP_MULLO, 16'hFFFF, 16'hFFFF, 3'd3, lat);
      checks++; if (lat != 16 || result !== 16'h0001) begin errors++; $display("FAIL mullo_ffff got lat %0d res %h exp 16/0001", lat, result); end
      settle();
   endtask

   task automatic test_div();
      int lat;
      issue(OP_DIVQ, 16'd1000, 16'd7, 3'd6, lat);
      checks++; if (lat != 16 || result !== 16'd142) begin errors++; $display("FAIL divq got lat %0d res %0d exp 16/142", lat, result); end
      checks++; if (div_zero !== 1'b0 || wb_reg !== 3'd6) begin errors++; $display("FAIL divq_flags got dz %b reg %0d exp 0/6", div_zero, wb_reg); end
      settle();
      issue(OP_DIVR, 16'd1000, 16'd7, 3'd1, lat);
      checks++; if (lat != 16 || result !== 16'd6) begin errors++; $display("FAIL divr got lat %0d res %0d exp 16/6", lat, result); end
      settle();
      issue(OP_DIVQ, 16'hFFFF, 16'd1, 3'd1, lat);
      checks++; if (result !== 16'hFFFF || div_zero !== 1'b0) begin errors++; $display("FAIL divq_by1 got %h dz %b exp ffff/0", result, div_zero); end
      settle();
   endtask

   task automatic test_div_zero();
      int lat;
      issue(OP_DIVQ, 16'd20, 16'd0, 3'd0, lat);
      checks++; if (lat != 16 || result !== 16'hFFFF) begin errors++; $display("FAIL divq_zero got lat %0d res %h exp 16/ffff", lat, result); end
      checks++; if (div_zero !== 1'b1 || wb_reg !== 3'd0 || wb_en !== 1'b1) begin errors++; $display("FAIL divq_zero_flags got dz %b reg %0d wb %b exp 1/0/1", div_zero, wb_reg, wb_en); end
      @(posedge clk); #1;
      checks++; if (div_zero !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL divzero_hold got dz %b done %b exp 1/0", div_zero, done); end
      settle();
      issue(OP_DIVR, 16'd20, 16'd0, 3'd3, lat);
      checks++; if (lat != 16 || result !== 16'd20 || div_zero !== 1'b1) begin errors++; $display("FAIL divr_zero got lat %0d res %0d dz %b exp 16/20/1", lat, result, div_zero); end
      settle();
   endtask

   task automatic test_start_while_busy();
      int lat = 0;
      @(negedge clk);
      start = 1'b1; op = OP_MULLO; src_a = 16'd3; src_b = 16'd4; dest_reg = 3'd2;
      @(posedge clk); #1;
      start = 1'b0;
      while (!done && lat < 40) begin
         @(negedge clk);
         if (lat == 3) begin
            start = 1'b1; op = OP_DIVQ; src_a = 16'd999; src_b = 16'd1; dest_reg = 3'd7;
         end else begin
            start = 1'b0; src_a = 16'hFFFF; src_b = 16'hFFFF;
         end
         @(posedge clk); #1;
         lat++;
      end
      start = 1'b0;
      checks++; if (lat != 16 || result !== 16'd12) begin errors++; $display("FAIL busy_start got lat %0d res %0d exp 16/12", lat, result); end
      checks++; if (wb_reg !== 3'd2 || div_zero !== 1'b0) begin errors++; $display("FAIL busy_start_wb got %0d/%b exp 2/0", wb_reg, div_zero); end
      @(posedge clk); #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_start_idle got %b exp 0", busy); end
      settle();
   endtask

   task automatic test_back_to_back();
      int lat = 0;
      int lat2 = 0;
      bit held = 1'b1;
      @(negedge clk);
      start = 1'b1; op = OP_MULLO; src_a = 16'h1234; src_b = 16'd2; dest_reg = 3'd1;
      @(posedge clk); #1;
      start = 1'b0;
      while (!done && lat < 40) begin
         @(negedge clk);
         if (lat == 14) begin
            start = 1'b1; op = OP_DIVR; src_a = 16'd100; src_b = 16'd9; dest_reg = 3'd3;
         end
         @(posedge clk); #1;
         lat++;
      end
      checks++; if (lat != 16 || result !== 16'h2468 || wb_reg !== 3'd1) begin errors++; $display("FAIL b2b_first got lat %0d res %h reg %0d exp 16/2468/1", lat, result, wb_reg); end
      while (lat2 < 40) begin
         @(posedge clk); #1;
         lat2++;
         if (lat2 == 1) begin
            checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL b2b_accept got busy %b done %b exp 1/0", busy, done); end
            start = 1'b0; src_a = 16'hFFFF; src_b = 16'h0;
         end
         if (done) break;
         if (result !== 16'h2468 || wb_reg !== 3'd1) held = 1'b0;
      end
      checks++; if (held !== 1'b1) begin errors++; $display("FAIL b2b_hold got %b exp 1", held); end
      checks++; if (lat2 != 17 || result !== 16'd1 || wb_reg !== 3'd3) begin errors++; $display("FAIL b2b_second got lat %0d res %0d reg %0d exp 17/1/3", lat2, result, wb_reg); end
      settle();
   endtask

   initial begin
      test_reset();
      test_mullo();
      test_mid_reset();
      test_mul_ext();
      test_div();
      test_div_zero();
      test_start_while_busy();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
